// File: rtl/spi_master.sv
// Mode-0 SPI master: shifts WIDTH-bit words out on sdo MSB first and captures sdi in the same frame.
// sck idles low; sdi is sampled on the falling sck edge, which is the clk edge that also advances sdo.
module spi_master #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             sck,
    output logic             sdo,
    input  logic             sdi,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH) + 1;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_TERM = BW'(WIDTH);

    logic             state_q, state_d;
    logic [PW-1:0]    ph_q, ph_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             sck_q, sck_d;
    logic             sdo_q, sdo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rxd_q, rxd_d;
    logic [BW-1:0]    bit_inc;

    assign bit_inc = bit_q + BW'(1);

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        sdo_d   = sdo_q;
        done_d  = 1'b0;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxd_d   = rxd_q;
        case (state_q)
            ST_IDLE: begin
                ph_d  = '0;
                sck_d = 1'b0;
                if (start) begin
                    state_d = ST_SHIFT;
                    tx_d    = tx_data;
                    sdo_d   = tx_data[WIDTH-1];
                    bit_d   = '0;
                end
            end
            default: begin
                if (ph_q == PH_LAST) begin
                    ph_d  = '0;
                    sck_d = ~sck_q;
                    // Falling edge: capture sdi and present the next bit.
                    if (sck_q) begin
                        rx_d = {rx_q[WIDTH-2:0], sdi};
                        if (bit_inc == BIT_TERM) begin
                            state_d = ST_IDLE;
                            rxd_d   = {rx_q[WIDTH-2:0], sdi};
                            done_d  = 1'b1;
                            sdo_d   = 1'b0;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_inc;
                            tx_d  = {tx_q[WIDTH-2:0], 1'b0};
                            sdo_d = tx_q[WIDTH-2];
                        end
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rxd_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxd_q   <= rxd_d;
        end
    end

    assign sck     = sck_q;
    assign sdo     = sdo_q;
    assign rx_data = rxd_q;
    assign busy    = (state_q == ST_SHIFT);
    assign done    = done_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a mode-0 slave model answers the default instance, a CLK_DIV=1 instance loops sdo to sdi.
// Stimulus queues expected frames; one monitor process checks every done pulse and every slave-received word.
module tb_spi_master;
    localparam int LAT0 = 2 * 32 * 4;
    localparam int LAT1 = 2 * 32 * 1;

    typedef struct {
        logic [31:0] tx;
        logic [31:0] rx;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start1;
    logic [31:0] tx_data, tx1;
    logic        sck, sdo, sdi, busy, done;
    logic [31:0] rx_data;
    logic        sck1, sdo1, busy1, done1;
    logic [31:0] rx1;

    int   cyc = 0;
    int   nchk = 0, nerr = 0;
    int   tmo = 0;
    logic stim_done = 1'b0;

    exp_t exp_q[$];
    exp_t exp1_q[$];

    // slave model state
    logic [31:0] reply_mem [0:63];
    int          nrep = 0;
    int          ri = 0, nr = 0, bitpos = 0, slv_frames = 0;
    logic [31:0] sh = '0, slv_word = '0;
    logic [4:0]  bsel;

    spi_master #(.WIDTH(32), .CLK_DIV(4)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .sck(sck), .sdo(sdo), .sdi(sdi), .rx_data(rx_data), .busy(busy), .done(done)
    );

    spi_master #(.WIDTH(32), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .tx_data(tx1),
        .sck(sck1), .sdo(sdo1), .sdi(sdo1), .rx_data(rx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave drives MSB first, updates on falling sck, samples sdo on rising sck.
    assign bsel = 5'(31 - bitpos);
    assign sdi  = reply_mem[ri][bsel];

    always @(posedge sck or negedge sck or negedge reset) begin
        if (!reset) begin
            if (nr != 0 || bitpos != 0) ri = ri + 1;
            nr = 0;
            bitpos = 0;
        end else if (sck) begin
            sh = {sh[30:0], sdo};
            nr = nr + 1;
            if (nr == 32) begin
                slv_word = sh;
                slv_frames = slv_frames + 1;
                nr = 0;
            end
        end else begin
            bitpos = bitpos + 1;
            if (bitpos == 32) begin
                bitpos = 0;
                ri = ri + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int rd = 0, srd = 0, sseen = 0, rd1 = 0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outs", {sck, sdo, busy, done, rx_data}, 64'd0);
            chk("reset_outs_div1", {sck1, sdo1, busy1, done1, rx1}, 64'd0);
        end else begin
            if (done) begin
                if (rd < exp_q.size()) begin
                    chk("rx_data", rx_data, exp_q[rd].rx);
                    chk("done_cycle", cyc, exp_q[rd].cyc);
                    chk("busy_at_done", busy, 0);
                    chk("sdo_at_done", sdo, 0);
                end else begin
                    chk("unexpected_done", rd, exp_q.size());
                end
                rd++;
            end
            if (slv_frames != sseen) begin
                sseen++;
                if (srd < exp_q.size()) chk("slave_rx", slv_word, exp_q[srd].tx);
                else chk("unexpected_slave_frame", srd, exp_q.size());
                srd++;
            end
            if (done1) begin
                if (rd1 < exp1_q.size()) begin
                    chk("rx_data_div1", rx1, exp1_q[rd1].rx);
                    chk("done_cycle_div1", cyc, exp1_q[rd1].cyc);
                    chk("busy_at_done_div1", busy1, 0);
                end else begin
                    chk("unexpected_done_div1", rd1, exp1_q.size());
                end
                rd1++;
            end
        end
        if (stim_done) begin
            chk("frames_done", rd, exp_q.size());
            chk("frames_slave", srd, exp_q.size());
            chk("frames_done_div1", rd1, exp1_q.size());
            chk("wait_timeouts", tmo, 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
            $finish;
        end else if (cyc > 40000) begin
            nerr++;
            $display("FAIL watchdog: got cycle %0d expected completion before 40000", cyc);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle0();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) tmo++;
    endtask

    task automatic issue(input logic [31:0] tx, input logic [31:0] rep);
        exp_t e;
        @(negedge clk);
        wait_idle0();
        reply_mem[nrep] = rep;
        nrep++;
        e.tx = tx; e.rx = rep; e.cyc = cyc + 1 + LAT0;
        exp_q.push_back(e);
        start = 1'b1;
        tx_data = tx;
        @(posedge clk);
        #1 start = 1'b0;
        tx_data = $urandom;
    endtask

    task automatic issue1(input logic [31:0] tx);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (busy1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy1) tmo++;
        e.tx = tx; e.rx = tx; e.cyc = cyc + 1 + LAT1;
        exp1_q.push_back(e);
        start1 = 1'b1;
        tx1 = tx;
        @(posedge clk);
        #1 start1 = 1'b0;
        tx1 = $urandom;
    endtask

    initial begin
        exp_t e;
        int   n;
        for (int i = 0; i < 64; i++) reply_mem[i] = '0;
        reset = 1'b1; start = 1'b0; start1 = 1'b0; tx_data = '0; tx1 = '0;
        #3 reset = 1'b0;
        start = 1'b1;
        tx_data = 32'hA5A50F0F;
        reply_mem[0] = 32'h12345678;
        nrep = 1;
        repeat (3) @(negedge clk);
        // Release with start held: accepted on the very next edge.
        reset = 1'b1;
        e.tx = 32'hA5A50F0F; e.rx = 32'h12345678; e.cyc = cyc + 1 + LAT0;
        exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;

        // start while busy is ignored
        issue(32'h00000001, $urandom);
        repeat (50) @(negedge clk);
        start = 1'b1;
        tx_data = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;

        // back-to-back with start held
        @(negedge clk);
        wait_idle0();
        reply_mem[nrep] = $urandom;
        e.tx = 32'hDEADBEEF; e.rx = reply_mem[nrep]; e.cyc = cyc + 1 + LAT0;
        exp_q.push_back(e);
        reply_mem[nrep + 1] = $urandom;
        e.tx = 32'hCAFEF00D; e.rx = reply_mem[nrep + 1]; e.cyc = cyc + 1 + LAT0 + 1 + LAT0;
        exp_q.push_back(e);
        nrep += 2;
        start = 1'b1;
        tx_data = 32'hDEADBEEF;
        @(posedge clk);
        #1 tx_data = 32'hCAFEF00D;
        n = 0;
        @(negedge clk);
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!done) tmo++;
        @(posedge clk);
        #1 start = 1'b0;

        // reset in the middle of bit 10: frame abandoned, no done
        @(negedge clk);
        wait_idle0();
        reply_mem[nrep] = $urandom;
        nrep++;
        start = 1'b1;
        tx_data = $urandom;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10 * 8 + 2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issue(32'h0000FFFF, $urandom);

        for (int k = 0; k < 5; k++) issue($urandom, $urandom);

        // CLK_DIV=1 loopback instance
        issue1(32'h80000001);
        for (int k = 0; k < 3; k++) issue1($urandom);

        @(negedge clk);
        wait_idle0();
        repeat (70) @(negedge clk);
        stim_done = 1'b1;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- FPGA-side SPI master that drives `sck` and shifts fixed-width words out on `sdo`, MSB first.
- Captures the word returned on `sdi` in the same frame.
- Serves as the initiator end of the 32-bit SPI link used by the heart-rate monitor, e.g. to push filtered readings or bench stimulus into a `sck`/`sdo`/`sdi` slave.
- Mode 0 (CPOL=0, CPHA=0), so it is bit-compatible with the team's SPI slave: the slave samples on rising `sck` and updates on falling `sck`.

Parameters:
- WIDTH, 32: bits per frame; also the width of `tx_data` and `rx_data`.
- CLK_DIV, 4: `clk` cycles per `sck` half-period; minimum 1. `sck` frequency = f_clk / (2*CLK_DIV).

Ports:
- clk  input  1  system clock; every register is on posedge clk.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request a frame; accepted only in IDLE.
- tx_data  input  WIDTH  word to transmit; sampled on the accepting edge only.
- sck  output  1  serial clock to slave; idle low; registered.
- sdo  output  1  serial data to slave (master out); registered.
- sdi  input  1  serial data from slave (master in).
- rx_data  output  WIDTH  last complete received word; registered.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes and `rx_data` is valid.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; `sck`=0, `sdo`=0, `busy`=0, `done`=0, `rx_data`=0. Bit counter, phase counter and shift registers are cleared. A frame in progress is abandoned immediately and no `done` is generated. The slave must also be reset to realign its bit counter; that is system-level and outside this block.
- States:
  - IDLE: `sck`=0, `busy`=0.
  - SHIFT: `busy`=1. Alternating LOW/HIGH half-phases of CLK_DIV cycles each.
- Acceptance: in IDLE with `start`=1 at edge E0, the tx shift register loads `tx_data` and the block goes to SHIFT.
  - After E0: `busy`=1, `sck`=0, `sdo`=tx_data[WIDTH-1].
- Timing, with edge k counted from E0 (k=0) and i = bit index 0..WIDTH-1:
  - Edge (2i+1)*CLK_DIV: `sck` rises. `sdo` is unchanged, so it has had CLK_DIV cycles of setup.
  - Edge (2i+2)*CLK_DIV: `sck` falls. `sdi` is shifted into the LSB of the rx shift register. `sdo` advances to the next tx bit, MSB first. `sdi` is stable for the whole high phase because the slave changes it only on falling `sck`.
  - Edge 2*WIDTH*CLK_DIV (last fall): `rx_data` is loaded with the full rx word; `done`=1 for exactly one cycle; `busy`=0; state=IDLE; `sdo` is held at 0.
- Latency: 2*WIDTH*CLK_DIV cycles from accept to `done` (256 with defaults). Exactly WIDTH rising `sck` edges per frame; no partial frames.
- Back-to-back frames: `start`=1 in the `done` cycle (state=IDLE) is accepted at the next edge. The inter-frame idle gap is 1 cycle with `sck` low.
- `start` while `busy`=1: ignored; no queueing. Changes to `tx_data` during a frame have no effect.
- `rx_data` holds its value between frames and changes only at `done`.
- `sdi` is used directly with no synchronizer; it originates from a flop clocked by this block's own `sck`.
- Counters:
  - Phase counter: ceil(log2(CLK_DIV)) bits, wraps 0..CLK_DIV-1.
  - Bit counter: ceil(log2(WIDTH))+1 bits; terminal count is WIDTH.
  - Width mismatches or overflow are not permitted.

Test Plan:
- Reset: hold reset=0 with `start`=1 -> `sck`=0, `sdo`=0, `busy`=0, `done`=0, `rx_data`=0 and no `sck` toggling. Release reset -> first frame starts one edge later.
- Single frame, defaults: tx_data=0xA5A50F0F, slave model returns 0x12345678 -> `sdo` sequence captured on rising `sck` equals 0xA5A50F0F, exactly 32 `sck` rises, `done` pulses once 256 cycles after accept, `rx_data`=0x12345678, `busy` falls with `done`.
- Start while busy: pulse `start` at cycle 50 with tx_data=0xFFFFFFFF during a 0x00000001 frame -> frame unaffected, slave receives 0x00000001, only one `done`.
- Back-to-back: hold `start`=1 with tx_data=0xDEADBEEF then 0xCAFEF00D -> 64 `sck` rises, `done` at cycles 256 and 513, 1-cycle `sck`-low gap, slave receives both words in order.
- Reset mid-frame: assert reset at bit 10 -> all outputs return to reset values the same cycle, with no `done`. Reset both ends and send 0x0000FFFF -> received correctly.
- CLK_DIV=1, sdo looped to sdi: tx_data=0x80000001 -> `sck` period 2 cycles, `done` at cycle 64, `rx_data`=0x80000001.
